// File: rtl/stream_rr_arbiter_pkg.sv
// ============================================================================
// Module : stream_rr_arbiter_pkg
// Brief  : Shared types for the round-robin stream arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/lzc.sv
// ============================================================================
// Module : lzc
// Brief  : Trailing-zero counter; reports the lowest set bit index of a vector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     i_vec,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_empty
);

    // Scanning downwards leaves the lowest set index; an empty vector yields 0.
    always_comb begin
        o_cnt   = '0;
        o_empty = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_cnt   = CNT_WIDTH'(i);
                o_empty = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module : stream_rr_arbiter
// Brief  : Fair, zero-latency round-robin merge of N valid/ready streams.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_INP      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    output logic [DATA_WIDTH-1:0]       oup_data_o,
    output logic [IDX_WIDTH-1:0]        oup_idx_o,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i
);

    if (N_INP == 1) begin : g_single
        assign oup_data_o  = inp_data_i;
        assign oup_idx_o   = '0;
        assign oup_valid_o = inp_valid_i[0];
        assign inp_ready_o = oup_ready_i;
    end else begin : g_multi
        localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(N_INP - 1);

        arb_state_e           r_state;
        logic [IDX_WIDTH-1:0] r_rr;
        logic [IDX_WIDTH-1:0] r_lock_idx;

        logic [N_INP-1:0]      w_masked;
        logic [IDX_WIDTH-1:0]  w_idx_masked;
        logic [IDX_WIDTH-1:0]  w_idx_all;
        logic                  w_empty_masked;
        logic                  w_empty_all;
        logic [IDX_WIDTH-1:0]  w_idx;
        logic                  w_valid;
        logic [DATA_WIDTH-1:0] w_lane [N_INP];

        for (genvar gi = 0; gi < N_INP; gi++) begin : g_lane
            assign w_masked[gi]    = inp_valid_i[gi] & (IDX_WIDTH'(gi) >= r_rr);
            assign w_lane[gi]      = inp_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign inp_ready_o[gi] = oup_ready_i & w_valid & (w_idx == IDX_WIDTH'(gi));
        end

        lzc #(.WIDTH(N_INP), .CNT_WIDTH(IDX_WIDTH)) u_lzc_masked (
            .i_vec   (w_masked),
            .o_cnt   (w_idx_masked),
            .o_empty (w_empty_masked)
        );

        lzc #(.WIDTH(N_INP), .CNT_WIDTH(IDX_WIDTH)) u_lzc_all (
            .i_vec   (inp_valid_i),
            .o_cnt   (w_idx_all),
            .o_empty (w_empty_all)
        );

        // Locked grant is held even if a higher-priority lane becomes valid.
        assign w_valid = (r_state == ST_LOCKED) | ~w_empty_all;
        assign w_idx   = (r_state == ST_LOCKED) ? r_lock_idx   :
                         !w_empty_masked        ? w_idx_masked : w_idx_all;

        assign oup_valid_o = w_valid;
        assign oup_idx_o   = w_idx;
        assign oup_data_o  = w_lane[w_idx];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state    <= ST_IDLE;
                r_rr       <= '0;
                r_lock_idx <= '0;
            end else if (w_valid) begin
                if (oup_ready_i) begin
                    r_state <= ST_IDLE;
                    r_rr    <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
                end else if (r_state == ST_IDLE) begin
                    r_state    <= ST_LOCKED;
                    r_lock_idx <= w_idx;
                end
            end
        end

`ifndef SYNTHESIS
        a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (r_state == ST_LOCKED) |-> inp_valid_i[r_lock_idx]);
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module : tb_stream_rr_arbiter
// Brief  : Directed scoreboard bench for N_INP=4 and N_INP=3 arbiters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    typedef struct {
        logic        valid;
        logic [1:0]  idx;
        logic [31:0] data;
        logic [3:0]  rdy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] data4;
    logic [3:0]   valid4;
    logic [3:0]   rdy4;
    logic [31:0]  odata4;
    logic [1:0]   idx4;
    logic         ovalid4;
    logic         ready4;
    logic [95:0]  data3;
    logic [2:0]   valid3;
    logic [2:0]   rdy3;
    logic [31:0]  odata3;
    logic [1:0]   idx3;
    logic         ovalid3;
    logic         ready3;

    exp_t q4[$];
    exp_t q3[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N_INP(4), .DATA_WIDTH(32)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_data_i  (data4),
        .inp_valid_i (valid4),
        .inp_ready_o (rdy4),
        .oup_data_o  (odata4),
        .oup_idx_o   (idx4),
        .oup_valid_o (ovalid4),
        .oup_ready_i (ready4)
    );

    stream_rr_arbiter #(.N_INP(3), .DATA_WIDTH(32)) u_dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_data_i  (data3),
        .inp_valid_i (valid3),
        .inp_ready_o (rdy3),
        .oup_data_o  (odata3),
        .oup_idx_o   (idx3),
        .oup_valid_o (ovalid3),
        .oup_ready_i (ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus, queues the expected outputs, and checks
    // them on the falling edge before the state-updating rising edge.
    task automatic step(input logic rst, input logic [3:0] v4, input logic r4,
                        input logic ev4, input logic [1:0] ei4,
                        input logic [2:0] v3, input logic r3,
                        input logic ev3, input logic [1:0] ei3);
        exp_t e;
        exp_t o;
        rst_n  = rst;
        valid4 = v4;
        ready4 = r4;
        valid3 = v3;
        ready3 = r3;
        e.valid = ev4;
        e.idx   = ei4;
        e.data  = 32'hA0 + 32'(ei4);
        e.rdy   = (ev4 && r4) ? (4'b0001 << ei4) : 4'b0000;
        q4.push_back(e);
        e.valid = ev3;
        e.idx   = ei3;
        e.data  = 32'hB0 + 32'(ei3);
        e.rdy   = (ev3 && r3) ? (4'b0001 << ei3) : 4'b0000;
        q3.push_back(e);
        @(negedge clk);
        o = q4.pop_front();
        chk("n4_valid", 32'(ovalid4), 32'(o.valid));
        chk("n4_idx",   32'(idx4),    32'(o.idx));
        chk("n4_data",  odata4,       o.data);
        chk("n4_ready", 32'(rdy4),    32'(o.rdy));
        o = q3.pop_front();
        chk("n3_valid", 32'(ovalid3), 32'(o.valid));
        chk("n3_idx",   32'(idx3),    32'(o.idx));
        chk("n3_data",  odata3,       o.data);
        chk("n3_ready", 32'(rdy3),    32'(o.rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data4[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 3; i++) data3[i*32 +: 32] = 32'hB0 + 32'(i);

        // Reset with nothing valid
        step(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 2'd0);

        // All valid, always ready: strict rotation 0..3 twice
        for (int c = 0; c < 8; c++)
            step(1'b1, 4'b1111, 1'b1, 1'b1, 2'(c % 4), 3'b000, 1'b1, 1'b0, 2'd0);

        // Sparse valids 1010 from pointer 0
        for (int c = 0; c < 4; c++)
            step(1'b1, 4'b1010, 1'b1, 1'b1, (c % 2 == 0) ? 2'd1 : 2'd3,
                 3'b000, 1'b1, 1'b0, 2'd0);

        // Stall on lane 2; lane 0 arrives but must not steal the grant
        step(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b0101, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b0101, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b0101, 1'b1, 1'b1, 2'd2, 3'b000, 1'b1, 1'b0, 2'd0);
        // Pointer now 3: lane 0 wins via wrap
        step(1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 3'b000, 1'b1, 1'b0, 2'd0);

        // Pointer 1: lock lane 1, then reset asynchronously mid-stall
        step(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 3'b000, 1'b1, 1'b0, 2'd0);
        step(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 3'b000, 1'b1, 1'b0, 2'd0);

        // Non-power-of-two wrap on the three-input arbiter
        for (int c = 0; c < 6; c++)
            step(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 3'b111, 1'b1, 1'b1, 2'(c % 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
